fitness_eval_ctrl: RTL and testbench
====================================

FITNESS_EVAL_CTRL -- requirements
Module: fitness_eval_ctrl

Interface
REQ-001 Parameters SHALL be NUM_PARTICLE_TYPE=3 (particle types), DATA_WIDTH=4 (energy entry width), SELF_FIT_LENGTH=10 (total-energy width), INDIVIDUAL_LENGTH=22 (packed individual), POP_SIZE=50 (individuals per run), IDX_WIDTH=8 (individual index width).
REQ-002 clk_i in 1: single clock; all logic on its rising edge.
REQ-003 rst_i in 1: reset, asynchronous, active-high.
REQ-004 start_i in 1: begin one evaluation run; sampled only in IDLE.
REQ-005 busy_o out 1 / done_o out 1: high outside IDLE / one-cycle pulse at run end.
REQ-006 cfg_rd_en_o out 1, cfg_addr_o out 4: config ROM read, sync read, 1-cycle latency.
REQ-007 cfg_self_i in DATA_WIDTH, cfg_inter_i in DATA_WIDTH: ROM data (self entry valid for addr<3 only; interaction entry addr = row*3+col).
REQ-008 self_energy_o, interact_energy_o out DATA_WIDTH; wrSelfEnergyValid_o, wrInteractEnergyValid_o out 1: datapath table-load port.
REQ-009 pop_rd_en_o out 1, pop_addr_o out IDX_WIDTH, pop_data_i in INDIVIDUAL_LENGTH: population RAM read, 1-cycle latency.
REQ-010 ind_vec_o out INDIVIDUAL_LENGTH, ind_idx_o out IDX_WIDTH, ind_valid_o out 1: individual issue to datapath.
REQ-011 eval_valid_i in 1, eval_energy_i in SELF_FIT_LENGTH, eval_idx_i in IDX_WIDTH: datapath result return.
REQ-012 fit_wr_en_o out 1, fit_wr_addr_o out IDX_WIDTH, fit_wr_data_o out SELF_FIT_LENGTH: fitness RAM write.
REQ-013 best_energy_o out SELF_FIT_LENGTH, best_idx_o out IDX_WIDTH, err_o out 1: run minimum and sticky protocol error.

Function
REQ-014 FSM SHALL have states IDLE, LOAD_CFG, STREAM, DRAIN, DONE.
REQ-015 IDLE & start_i -> LOAD_CFG next cycle; clear issue/result counters, best_energy_o to all-ones, best_idx_o to 0, err_o to 0.
REQ-016 LOAD_CFG: cfg_rd_en_o=1, cfg_addr_o 0..8 one per cycle (9 cycles); after addr 8 -> STREAM.
REQ-017 Table-load valids SHALL be cfg_rd_en_o delayed 1 cycle; wrSelfEnergyValid_o additionally gated by delayed addr<3; energy outputs pass ROM data through.
REQ-018 STREAM: pop_rd_en_o=1, pop_addr_o 0..POP_SIZE-1 one per cycle, no gaps; after POP_SIZE-1 -> DRAIN.
REQ-019 ind_valid_o/ind_idx_o SHALL be pop_rd_en_o/pop_addr_o delayed 1 cycle, ind_vec_o = pop_data_i; first ind_valid_o falls the cycle after the last table-load valid.
REQ-020 Each eval_valid_i in STREAM or DRAIN SHALL same-cycle drive fit_wr_en_o=1, fit_wr_addr_o=eval_idx_i, fit_wr_data_o=eval_energy_i, and increment result counter.
REQ-021 Best update SHALL use strict eval_energy_i < best_energy_o (ties keep earlier result), registered.
REQ-022 DRAIN -> DONE when result counter reaches POP_SIZE (including a result arriving that cycle); DONE asserts done_o one cycle then -> IDLE.
REQ-023 start_i outside IDLE SHALL be ignored; best/err outputs hold until next start.
REQ-024 err_o SHALL set on eval_valid_i in IDLE/LOAD_CFG/DONE, or eval_idx_i >= POP_SIZE; such results are not written nor counted.
REQ-025 Result arrival order/latency SHALL be irrelevant; controller never throttles the datapath.

Reset
REQ-026 rst_i SHALL force IDLE, all counters 0, every output 0 except best_energy_o all-ones, immediately and asynchronously, including mid-run; no run resumes after reset.

Structure
REQ-027 Shared package SHALL hold the parameters above, FSM state encoding, and CFG_DEPTH=NUM_PARTICLE_TYPE**2.
REQ-028 One sub-module natural: fitness_min_tracker (compare/hold of best energy and index).

Verification
REQ-029 Bench with fitness_eval (4-cycle latency); ROM self {1,2,3}, matrix rows {10,4,1},{4,10,5},{1,5,10}.
REQ-030 All-type-0 individual -> fit_wr_data_o=211; all-type-2 -> 233; all-type-1 -> 222.
REQ-031 50 random individuals -> 50 fitness writes to addrs 0..49, done_o one pulse, run length 9+50+~5 cycles.
REQ-032 Two individuals tie at minimum energy -> best_idx_o = lower index.
REQ-033 rst_i asserted mid-STREAM -> busy_o=0 same cycle, no further writes; next start_i completes normally.
REQ-034 eval_valid_i injected in IDLE or with idx 60 -> err_o=1, no write.

Source files
------------

// File: rtl/fitness_eval_ctrl_pkg.sv
// Shared constants and FSM encoding for the fitness evaluation controller.
package fitness_eval_ctrl_pkg;

    localparam int NUM_PARTICLE_TYPE = 3;
    localparam int DATA_WIDTH        = 4;
    localparam int SELF_FIT_LENGTH   = 10;
    localparam int INDIVIDUAL_LENGTH = 22;
    localparam int POP_SIZE          = 50;
    localparam int IDX_WIDTH         = 8;

    // Interaction matrix is square over the particle types.
    localparam int CFG_DEPTH      = NUM_PARTICLE_TYPE ** 2;
    localparam int CFG_ADDR_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_CFG = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Results are only legitimate while individuals are in flight.
    function automatic logic accepts_results(input state_t s);
        return (s == ST_STREAM) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/fitness_min_tracker.sv
// Holds the lowest energy seen in the current run and the index that produced it.
module fitness_min_tracker #(
    parameter int ENERGY_WIDTH = 10,
    parameter int IDX_WIDTH    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear,
    input  logic                    upd_valid,
    input  logic [ENERGY_WIDTH-1:0] upd_energy,
    input  logic [IDX_WIDTH-1:0]    upd_idx,
    output logic [ENERGY_WIDTH-1:0] best_energy,
    output logic [IDX_WIDTH-1:0]    best_idx
);

    // Strict less-than so that on a tie the earlier result is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            best_energy <= '1;
            best_idx    <= '0;
        end else if (clear) begin
            best_energy <= '1;
            best_idx    <= '0;
        end else if (upd_valid && (upd_energy < best_energy)) begin
            best_energy <= upd_energy;
            best_idx    <= upd_idx;
        end
    end

endmodule

// File: rtl/fitness_eval_ctrl.sv
// Sequences one evaluation run: load energy tables, stream the population to
// the datapath, collect fitness results and track the run minimum.
module fitness_eval_ctrl #(
    parameter int NUM_PARTICLE_TYPE = 3,
    parameter int DATA_WIDTH        = 4,
    parameter int SELF_FIT_LENGTH   = 10,
    parameter int INDIVIDUAL_LENGTH = 22,
    parameter int POP_SIZE          = 50,
    parameter int IDX_WIDTH         = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         cfg_rd_en_o,
    output logic [3:0]                   cfg_addr_o,
    input  logic [DATA_WIDTH-1:0]        cfg_self_i,
    input  logic [DATA_WIDTH-1:0]        cfg_inter_i,
    output logic [DATA_WIDTH-1:0]        self_energy_o,
    output logic [DATA_WIDTH-1:0]        interact_energy_o,
    output logic                         wrSelfEnergyValid_o,
    output logic                         wrInteractEnergyValid_o,
    output logic                         pop_rd_en_o,
    output logic [IDX_WIDTH-1:0]         pop_addr_o,
    input  logic [INDIVIDUAL_LENGTH-1:0] pop_data_i,
    output logic [INDIVIDUAL_LENGTH-1:0] ind_vec_o,
    output logic [IDX_WIDTH-1:0]         ind_idx_o,
    output logic                         ind_valid_o,
    input  logic                         eval_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0]   eval_energy_i,
    input  logic [IDX_WIDTH-1:0]         eval_idx_i,
    output logic                         fit_wr_en_o,
    output logic [IDX_WIDTH-1:0]         fit_wr_addr_o,
    output logic [SELF_FIT_LENGTH-1:0]   fit_wr_data_o,
    output logic [SELF_FIT_LENGTH-1:0]   best_energy_o,
    output logic [IDX_WIDTH-1:0]         best_idx_o,
    output logic                         err_o
);

    import fitness_eval_ctrl_pkg::*;

    localparam int CFG_LAST = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE - 1;

    state_t                    state_reg;
    state_t                    state_next;
    logic [CFG_ADDR_WIDTH-1:0] cfg_cnt_reg;
    logic [IDX_WIDTH-1:0]      issue_cnt_reg;
    logic [IDX_WIDTH-1:0]      result_cnt_reg;
    logic                      cfg_vld_reg;
    logic                      self_vld_reg;
    logic                      ind_valid_reg;
    logic [IDX_WIDTH-1:0]      ind_idx_reg;
    logic                      err_reg;

    logic start_run;
    logic last_cfg;
    logic last_issue;
    logic idx_in_range;
    logic result_ok;
    logic result_bad;
    logic results_complete;

    assign start_run    = (state_reg == ST_IDLE) && start_i;
    assign last_cfg     = (cfg_cnt_reg == CFG_ADDR_WIDTH'(CFG_LAST));
    assign last_issue   = (issue_cnt_reg == IDX_WIDTH'(POP_SIZE - 1));
    assign idx_in_range = (eval_idx_i < IDX_WIDTH'(POP_SIZE));
    assign result_ok    = eval_valid_i && accepts_results(state_reg) && idx_in_range;
    assign result_bad   = eval_valid_i && !(accepts_results(state_reg) && idx_in_range);
    // A result landing in the same cycle counts toward completion.
    assign results_complete =
        ((result_cnt_reg + IDX_WIDTH'(result_ok)) >= IDX_WIDTH'(POP_SIZE));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start_i) state_next = ST_LOAD_CFG;
            ST_LOAD_CFG: if (last_cfg) state_next = ST_STREAM;
            ST_STREAM:   if (last_issue) state_next = ST_DRAIN;
            ST_DRAIN:    if (results_complete) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Config address, issue and result counters; all cleared when a run starts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_cnt_reg    <= '0;
            issue_cnt_reg  <= '0;
            result_cnt_reg <= '0;
        end else if (start_run) begin
            cfg_cnt_reg    <= '0;
            issue_cnt_reg  <= '0;
            result_cnt_reg <= '0;
        end else begin
            if (state_reg == ST_LOAD_CFG) cfg_cnt_reg <= cfg_cnt_reg + 1'b1;
            if (state_reg == ST_STREAM) issue_cnt_reg <= issue_cnt_reg + 1'b1;
            if (result_ok) result_cnt_reg <= result_cnt_reg + 1'b1;
        end
    end

    // Align table-load and issue valids with the 1-cycle memory read latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_vld_reg   <= 1'b0;
            self_vld_reg  <= 1'b0;
            ind_valid_reg <= 1'b0;
            ind_idx_reg   <= '0;
        end else begin
            cfg_vld_reg   <= cfg_rd_en_o;
            self_vld_reg  <= cfg_rd_en_o && (cfg_addr_o < CFG_ADDR_WIDTH'(NUM_PARTICLE_TYPE));
            ind_valid_reg <= pop_rd_en_o;
            ind_idx_reg   <= pop_addr_o;
        end
    end

    // Sticky protocol error: set wins over the clear at run start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else if (result_bad) begin
            err_reg <= 1'b1;
        end else if (start_run) begin
            err_reg <= 1'b0;
        end
    end

    fitness_min_tracker #(
        .ENERGY_WIDTH (SELF_FIT_LENGTH),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_min_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear       (start_run),
        .upd_valid   (result_ok),
        .upd_energy  (eval_energy_i),
        .upd_idx     (eval_idx_i),
        .best_energy (best_energy_o),
        .best_idx    (best_idx_o)
    );

    assign busy_o      = (state_reg != ST_IDLE);
    assign done_o      = (state_reg == ST_DONE);
    assign cfg_rd_en_o = (state_reg == ST_LOAD_CFG);
    assign cfg_addr_o  = cfg_rd_en_o ? cfg_cnt_reg : '0;
    assign pop_rd_en_o = (state_reg == ST_STREAM);
    assign pop_addr_o  = pop_rd_en_o ? issue_cnt_reg : '0;

    // Data buses are zeroed while their valid is low so reset leaves them quiet.
    assign wrInteractEnergyValid_o = cfg_vld_reg;
    assign wrSelfEnergyValid_o     = self_vld_reg;
    assign interact_energy_o       = cfg_vld_reg ? cfg_inter_i : '0;
    assign self_energy_o           = cfg_vld_reg ? cfg_self_i : '0;

    assign ind_valid_o = ind_valid_reg;
    assign ind_idx_o   = ind_idx_reg;
    assign ind_vec_o   = ind_valid_reg ? pop_data_i : '0;

    assign fit_wr_en_o   = result_ok;
    assign fit_wr_addr_o = result_ok ? eval_idx_i : '0;
    assign fit_wr_data_o = result_ok ? eval_energy_i : '0;

    assign err_o = err_reg;

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Directed bench: config ROM, population RAM and a 4-cycle fitness datapath
// model around the controller.
module tb_fitness_eval_ctrl;

    localparam int POP = 50;
    localparam int REF_SELF  [3] = '{1, 2, 3};
    localparam int REF_INTER [9] = '{10, 4, 1, 4, 10, 5, 1, 5, 10};
    localparam logic [21:0] ALL_T0  = 22'h000000;
    localparam logic [21:0] ALL_T2  = 22'h2AAAAA;
    localparam logic [21:0] ALL_T1  = 22'h155555;
    localparam logic [21:0] ALT_0_2 = 22'h088888;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        busy_o, done_o;
    logic        cfg_rd_en_o;
    logic [3:0]  cfg_addr_o;
    logic [3:0]  cfg_self_i = '0, cfg_inter_i = '0;
    logic [3:0]  self_energy_o, interact_energy_o;
    logic        wrSelfEnergyValid_o, wrInteractEnergyValid_o;
    logic        pop_rd_en_o;
    logic [7:0]  pop_addr_o;
    logic [21:0] pop_data_i = '0;
    logic [21:0] ind_vec_o;
    logic [7:0]  ind_idx_o;
    logic        ind_valid_o;
    logic        eval_valid_i;
    logic [9:0]  eval_energy_i;
    logic [7:0]  eval_idx_i;
    logic        fit_wr_en_o;
    logic [7:0]  fit_wr_addr_o;
    logic [9:0]  fit_wr_data_o;
    logic [9:0]  best_energy_o;
    logic [7:0]  best_idx_o;
    logic        err_o;

    logic        inj_valid = 1'b0;
    logic [9:0]  inj_energy = '0;
    logic [7:0]  inj_idx = '0;

    logic        dp_v [4];
    logic [9:0]  dp_e [4];
    logic [7:0]  dp_i [4];
    logic [3:0]  self_tab [3];
    logic [3:0]  inter_tab [9];
    int          ld_cnt;
    logic [21:0] pop_mem [POP];

    int          checks = 0;
    int          failures = 0;
    int          wr_cnt [64];
    logic [9:0]  wr_data [64];
    int          total_wr, done_pulses, done_cyc, bad_addr_wr;
    logic        err_early;

    always #5 clk = ~clk;

    assign eval_valid_i  = inj_valid | dp_v[3];
    assign eval_energy_i = inj_valid ? inj_energy : dp_e[3];
    assign eval_idx_i    = inj_valid ? inj_idx : dp_i[3];

    fitness_eval_ctrl dut (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .start_i                 (start_i),
        .busy_o                  (busy_o),
        .done_o                  (done_o),
        .cfg_rd_en_o             (cfg_rd_en_o),
        .cfg_addr_o              (cfg_addr_o),
        .cfg_self_i              (cfg_self_i),
        .cfg_inter_i             (cfg_inter_i),
        .self_energy_o           (self_energy_o),
        .interact_energy_o       (interact_energy_o),
        .wrSelfEnergyValid_o     (wrSelfEnergyValid_o),
        .wrInteractEnergyValid_o (wrInteractEnergyValid_o),
        .pop_rd_en_o             (pop_rd_en_o),
        .pop_addr_o              (pop_addr_o),
        .pop_data_i              (pop_data_i),
        .ind_vec_o               (ind_vec_o),
        .ind_idx_o               (ind_idx_o),
        .ind_valid_o             (ind_valid_o),
        .eval_valid_i            (eval_valid_i),
        .eval_energy_i           (eval_energy_i),
        .eval_idx_i              (eval_idx_i),
        .fit_wr_en_o             (fit_wr_en_o),
        .fit_wr_addr_o           (fit_wr_addr_o),
        .fit_wr_data_o           (fit_wr_data_o),
        .best_energy_o           (best_energy_o),
        .best_idx_o              (best_idx_o),
        .err_o                   (err_o)
    );

    // Reference energy from the fixed table values.
    function automatic int ref_energy(input logic [21:0] v);
        int e = 0;
        for (int p = 0; p < 11; p++) e += REF_SELF[int'(v[2*p +: 2])];
        for (int p = 0; p < 10; p++) begin
            int a = int'(v[2*p +: 2]);
            int b = int'(v[2*p+2 +: 2]);
            e += REF_INTER[a*3+b] + REF_INTER[b*3+a];
        end
        return e;
    endfunction

    // Datapath energy from the tables it was loaded with.
    function automatic logic [9:0] dp_energy(input logic [21:0] v);
        int e = 0;
        for (int p = 0; p < 11; p++) e += int'(self_tab[int'(v[2*p +: 2]) % 3]);
        for (int p = 0; p < 10; p++) begin
            int a = int'(v[2*p +: 2]) % 3;
            int b = int'(v[2*p+2 +: 2]) % 3;
            e += int'(inter_tab[a*3+b]) + int'(inter_tab[b*3+a]);
        end
        return 10'(e);
    endfunction

    // Config ROM, synchronous read.
    always @(posedge clk) begin
        if (cfg_rd_en_o) begin
            cfg_inter_i <= 4'(REF_INTER[int'(cfg_addr_o) % 9]);
            cfg_self_i  <= (cfg_addr_o < 4'd3) ? 4'(REF_SELF[int'(cfg_addr_o)]) : 4'hF;
        end
    end

    // Population RAM, synchronous read.
    always @(posedge clk) begin
        if (pop_rd_en_o) pop_data_i <= pop_mem[int'(pop_addr_o) % POP];
    end

    // Datapath table capture.
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            ld_cnt <= 0;
        end else if (wrInteractEnergyValid_o) begin
            inter_tab[ld_cnt] <= interact_energy_o;
            if (wrSelfEnergyValid_o && ld_cnt < 3) self_tab[ld_cnt] <= self_energy_o;
            ld_cnt <= (ld_cnt == 8) ? 0 : ld_cnt + 1;
        end
    end

    // Datapath pipeline, 4 cycles from ind_valid_o to eval_valid_i.
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 4; k++) begin
                dp_v[k] <= 1'b0;
                dp_e[k] <= '0;
                dp_i[k] <= '0;
            end
        end else begin
            dp_v[0] <= ind_valid_o;
            dp_e[0] <= dp_energy(ind_vec_o);
            dp_i[0] <= ind_idx_o;
            for (int k = 1; k < 4; k++) begin
                dp_v[k] <= dp_v[k-1];
                dp_e[k] <= dp_e[k-1];
                dp_i[k] <= dp_i[k-1];
            end
        end
    end

    // Starts a run and records writes, done pulses and timing for 80 cycles.
    task automatic run_collect(input int inj_cyc, input int inj_id, input int restart_cyc);
        for (int a = 0; a < 64; a++) begin
            wr_cnt[a]  = 0;
            wr_data[a] = '0;
        end
        total_wr = 0; done_pulses = 0; done_cyc = -1; bad_addr_wr = 0; err_early = 1'bx;
        @(negedge clk);
        start_i = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            start_i    = (cyc == restart_cyc);
            inj_valid  = (cyc == inj_cyc);
            inj_idx    = 8'(inj_id);
            inj_energy = 10'd0;
            #1;
            if (fit_wr_en_o) begin
                total_wr++;
                if (fit_wr_addr_o < 8'd64) begin
                    wr_cnt[int'(fit_wr_addr_o)]++;
                    wr_data[int'(fit_wr_addr_o)] = fit_wr_data_o;
                end
                if (fit_wr_addr_o >= 8'd50) bad_addr_wr++;
            end
            if (done_o) begin
                done_pulses++;
                done_cyc = cyc;
            end
            if (cyc == 2) err_early = err_o;
        end
        start_i   = 1'b0;
        inj_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done_o); end
        checks++; if (best_energy_o !== 10'h3FF) begin failures++; $display("FAIL reset_best_energy got=%0h exp=3ff", best_energy_o); end
        checks++; if (best_idx_o !== 8'd0) begin failures++; $display("FAIL reset_best_idx got=%0d exp=0", best_idx_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        checks++; if ({cfg_rd_en_o, pop_rd_en_o, ind_valid_o, fit_wr_en_o} !== 4'b0) begin
            failures++; $display("FAIL reset_enables got=%b exp=0000", {cfg_rd_en_o, pop_rd_en_o, ind_valid_o, fit_wr_en_o});
        end
        $display("reset: busy=%0b best=%0h err=%0b", busy_o, best_energy_o, err_o);
        rst_i = 1'b0;
    endtask

    task automatic test_full_run();
        run_collect(-1, 0, 20);  // start pulsed mid-STREAM must be ignored
        checks++; if (total_wr != 50) begin failures++; $display("FAIL run_writes got=%0d exp=50", total_wr); end
        checks++; if (bad_addr_wr != 0) begin failures++; $display("FAIL run_bad_addr got=%0d exp=0", bad_addr_wr); end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL run_done_pulses got=%0d exp=1", done_pulses); end
        checks++; if (done_cyc != 64) begin failures++; $display("FAIL run_done_cycle got=%0d exp=64", done_cyc); end
        checks++; if (wr_data[0] !== 10'd211) begin failures++; $display("FAIL energy_all_t0 got=%0d exp=211", wr_data[0]); end
        checks++; if (wr_data[1] !== 10'd233) begin failures++; $display("FAIL energy_all_t2 got=%0d exp=233", wr_data[1]); end
        checks++; if (wr_data[2] !== 10'd222) begin failures++; $display("FAIL energy_all_t1 got=%0d exp=222", wr_data[2]); end
        for (int a = 0; a < POP; a++) begin
            logic [9:0] exp_e;
            exp_e = 10'(ref_energy(pop_mem[a]));
            checks++;
            if (wr_cnt[a] != 1 || wr_data[a] !== exp_e) begin
                failures++;
                $display("FAIL fit_write idx=%0d count=%0d got=%0d exp=%0d", a, wr_cnt[a], wr_data[a], exp_e);
            end
        end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL run_idle_after got=%0b exp=0", busy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL run_err got=%0b exp=0", err_o); end
        $display("full_run: writes=%0d done_cycle=%0d best=%0d idx=%0d", total_wr, done_cyc, best_energy_o, best_idx_o);
    endtask

    task automatic test_tie();
        checks++; if (best_energy_o !== 10'd41) begin failures++; $display("FAIL tie_best_energy got=%0d exp=41", best_energy_o); end
        checks++; if (best_idx_o !== 8'd7) begin failures++; $display("FAIL tie_best_idx got=%0d exp=7", best_idx_o); end
        $display("tie: best=%0d idx=%0d", best_energy_o, best_idx_o);
    endtask

    task automatic test_idle_error();
        @(negedge clk);
        inj_valid = 1'b1; inj_idx = 8'd5; inj_energy = 10'd3;
        #1;
        checks++; if (fit_wr_en_o !== 1'b0) begin failures++; $display("FAIL idle_inject_write got=%0b exp=0", fit_wr_en_o); end
        @(negedge clk);
        inj_valid = 1'b0;
        #1;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL idle_inject_err got=%0b exp=1", err_o); end
        checks++; if (best_energy_o !== 10'd41 || best_idx_o !== 8'd7) begin
            failures++; $display("FAIL idle_inject_best got=%0d/%0d exp=41/7", best_energy_o, best_idx_o);
        end
        $display("idle_error: err=%0b best=%0d", err_o, best_energy_o);
    endtask

    task automatic test_stream_error();
        run_collect(12, 60, -1);
        checks++; if (err_early !== 1'b0) begin failures++; $display("FAIL err_clear_on_start got=%0b exp=0", err_early); end
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL idx60_err got=%0b exp=1", err_o); end
        checks++; if (total_wr != 50 || bad_addr_wr != 0) begin
            failures++; $display("FAIL idx60_writes got=%0d bad=%0d exp=50 bad=0", total_wr, bad_addr_wr);
        end
        checks++; if (best_energy_o !== 10'd41) begin failures++; $display("FAIL idx60_best got=%0d exp=41", best_energy_o); end
        $display("stream_error: err=%0b writes=%0d best=%0d", err_o, total_wr, best_energy_o);
    endtask

    task automatic test_reset_mid_run();
        int late_wr = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (18) @(negedge clk);
        checks++; if (pop_rd_en_o !== 1'b1) begin failures++; $display("FAIL mid_in_stream got=%0b exp=1", pop_rd_en_o); end
        #1 rst_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0 || pop_rd_en_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset_async busy=%0b pop_rd=%0b exp=0/0", busy_o, pop_rd_en_o);
        end
        checks++; if (best_energy_o !== 10'h3FF) begin failures++; $display("FAIL mid_reset_best got=%0h exp=3ff", best_energy_o); end
        @(negedge clk);
        rst_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (fit_wr_en_o) late_wr++;
        end
        checks++; if (late_wr != 0) begin failures++; $display("FAIL mid_reset_writes got=%0d exp=0", late_wr); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_reset_resumed got=%0b exp=0", busy_o); end
        $display("reset_mid_run: late_writes=%0d busy=%0b", late_wr, busy_o);
    endtask

    task automatic test_after_reset();
        run_collect(-1, 0, -1);
        checks++; if (total_wr != 50) begin failures++; $display("FAIL rerun_writes got=%0d exp=50", total_wr); end
        checks++; if (done_cyc != 64) begin failures++; $display("FAIL rerun_done_cycle got=%0d exp=64", done_cyc); end
        checks++; if (best_energy_o !== 10'd41 || best_idx_o !== 8'd7) begin
            failures++; $display("FAIL rerun_best got=%0d/%0d exp=41/7", best_energy_o, best_idx_o);
        end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rerun_err got=%0b exp=0", err_o); end
        $display("after_reset: writes=%0d done_cycle=%0d best=%0d", total_wr, done_cyc, best_energy_o);
    endtask

    initial begin
        pop_mem[0] = ALL_T0;
        pop_mem[1] = ALL_T2;
        pop_mem[2] = ALL_T1;
        for (int a = 3; a < POP; a++) begin
            logic [21:0] v;
            v = '0;
            for (int p = 0; p < 11; p++) v[2*p +: 2] = 2'($urandom_range(0, 2));
            if (ref_energy(v) <= 41) v = ALL_T1;
            pop_mem[a] = v;
        end
        pop_mem[7]  = ALT_0_2;
        pop_mem[23] = ALT_0_2;

        test_reset();
        test_full_run();
        test_tie();
        test_idle_error();
        test_stream_error();
        test_reset_mid_run();
        test_after_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
